otter_pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipelined OTTER (IF/DE/EX/MEM/WB). It owns the per-stage invalid (bubble) bits, generates all stage stall enables, detects load-use hazards, squashes wrong-path instructions on taken branches/jumps, and holds the pipeline while a multi-cycle data-memory access completes. It also produces the EX-stage operand forwarding selects and two performance counters.

---
 rtl/otter_pipe_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_otter_pipe_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_pipe_ctrl.sv
// OTTER pipeline hazard/sequencing controller.
// Owns bubble bits, stalls, squash, mem-wait FSM, forwarding, perf counters.
module otter_pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_rs1_used,
  input  logic             de_rs2_used,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             ex_rs1_used,
  input  logic             ex_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regWrite,
  input  logic             ex_memRead2,
  input  logic             branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regWrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regWrite,
  output logic             stall_pc,
  output logic             stall_if,
  output logic             stall_de,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             if_de_invalid,
  output logic             de_ex_invalid,
  output logic             ex_mem_invalid,
  output logic             mem_wb_invalid,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             ifde_q, ifde_d;
  logic             deex_q, deex_d;
  logic             exmem_q, exmem_d;
  logic             memwb_q, memwb_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic de_v, ex_v, mem_v, wb_v;
  logic req_miss, timeout, mem_stall;
  logic flush, lu_raw, load_use;
  logic front_stall;
  logic mem_fwd_ok, wb_fwd_ok;

  // Hazard detection and stall generation for the current cycle
  always_comb begin
    de_v  = ~ifde_q;
    ex_v  = ~deex_q;
    mem_v = ~exmem_q;
    wb_v  = ~memwb_q;

    req_miss = mem_v & mem_req & ~mem_ready;
    timeout  = (state_q == S_WAIT) & ~mem_ready
             & (wcnt_q == WLAST);

    if (state_q == S_RUN) begin
      mem_stall = req_miss;
    end else begin
      mem_stall = ~mem_ready & ~timeout;
    end

    flush = ex_v & branch_taken & ~mem_stall;

    lu_raw = ex_v & ex_memRead2 & ex_regWrite
           & (ex_rd != 5'd0) & de_v
           & ((de_rs1_used & (de_rs1 == ex_rd))
            | (de_rs2_used & (de_rs2 == ex_rd)));
    load_use = lu_raw & ~flush & ~mem_stall;

    front_stall = mem_stall | load_use;
    stall_pc    = front_stall;
    stall_if    = front_stall;
    stall_de    = front_stall;
    stall_ex    = mem_stall;
    stall_mem   = mem_stall;

    mem_timeout = timeout & ~RESET;
  end

  // EX operand forwarding; the younger MEM producer wins over WB
  always_comb begin
    mem_fwd_ok = mem_v & mem_regWrite & (mem_rd != 5'd0);
    wb_fwd_ok  = wb_v & wb_regWrite & (wb_rd != 5'd0);

    fwd_a_sel = 2'd0;
    if (ex_rs1_used & mem_fwd_ok & (mem_rd == ex_rs1)) begin
      fwd_a_sel = 2'd1;
    end else if (ex_rs1_used & wb_fwd_ok & (wb_rd == ex_rs1)) begin
      fwd_a_sel = 2'd2;
    end

    fwd_b_sel = 2'd0;
    if (ex_rs2_used & mem_fwd_ok & (mem_rd == ex_rs2)) begin
      fwd_b_sel = 2'd1;
    end else if (ex_rs2_used & wb_fwd_ok & (wb_rd == ex_rs2)) begin
      fwd_b_sel = 2'd2;
    end
  end

  // Next-state: memory FSM, bubble bits and counters
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;

    unique case (state_q)
      S_RUN: begin
        if (req_miss) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (mem_ready | timeout) begin
          state_d = S_RUN;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      default: state_d = S_RUN;
    endcase

    ifde_d = stall_if ? ifde_q : flush;

    if (!stall_de) begin
      deex_d = ifde_q | flush;
    end else if (!stall_ex) begin
      deex_d = 1'b1;
    end else begin
      deex_d = deex_q;
    end

    exmem_d = stall_ex ? exmem_q : deex_q;

    // An abandoned access leaves MEM as a bubble, never reaching WB
    if (timeout) begin
      memwb_d = 1'b1;
    end else if (!stall_mem) begin
      memwb_d = exmem_q;
    end else begin
      memwb_d = 1'b1;
    end

    stall_cycles_d = stall_cycles_q;
    if (front_stall) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    flush_count_d = flush_count_q;
    if (flush) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= S_RUN;
      wcnt_q         <= '0;
      ifde_q         <= 1'b1;
      deex_q         <= 1'b1;
      exmem_q        <= 1'b1;
      memwb_q        <= 1'b1;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      ifde_q         <= ifde_d;
      deex_q         <= deex_d;
      exmem_q        <= exmem_d;
      memwb_q        <= memwb_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign if_de_invalid  = ifde_q;
  assign de_ex_invalid  = deex_q;
  assign ex_mem_invalid = exmem_q;
  assign mem_wb_invalid = memwb_q;
  assign stall_cycles   = stall_cycles_q;
  assign flush_count    = flush_count_q;

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Bench for otter_pipe_ctrl: directed scenarios then random traffic
// against a cycle-level reference model.
module tb_otter_pipe_ctrl;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd;
  logic [4:0]  mem_rd, wb_rd;
  logic        de_rs1_used, de_rs2_used;
  logic        ex_rs1_used, ex_rs2_used;
  logic        ex_regWrite, ex_memRead2, branch_taken;
  logic        mem_regWrite, mem_req, mem_ready, wb_regWrite;
  logic        stall_pc, stall_if, stall_de, stall_ex, stall_mem;
  logic        if_de_invalid, de_ex_invalid;
  logic        ex_mem_invalid, mem_wb_invalid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  otter_pipe_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .ex_rd(ex_rd), .ex_regWrite(ex_regWrite),
    .ex_memRead2(ex_memRead2), .branch_taken(branch_taken),
    .mem_rd(mem_rd), .mem_regWrite(mem_regWrite),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
    .stall_pc(stall_pc), .stall_if(stall_if),
    .stall_de(stall_de), .stall_ex(stall_ex),
    .stall_mem(stall_mem),
    .if_de_invalid(if_de_invalid), .de_ex_invalid(de_ex_invalid),
    .ex_mem_invalid(ex_mem_invalid), .mem_wb_invalid(mem_wb_invalid),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: bubble per stage boundary, age of pending access
  bit          inv[4];
  int          age;
  logic [31:0] sc, fc;
  logic        e_ms, e_to, e_fl, e_lu;
  logic [1:0]  e_fa, e_fb;
  bit          n0, n1, n2, n3;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic used,
                                         input logic [4:0] rs);
    logic [4:0] rd[2];
    logic       ok[2];
    rd[0] = mem_rd;
    ok[0] = !inv[2] && mem_regWrite;
    rd[1] = wb_rd;
    ok[1] = !inv[3] && wb_regWrite;
    for (int k = 0; k < 2; k++)
      if (used && ok[k] && rd[k] != 0 && rd[k] == rs)
        return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic predict();
    bit dv, ev, mv, hit;
    dv = !inv[0];
    ev = !inv[1];
    mv = !inv[2];
    e_to = !RESET && age == TO && !mem_ready;
    if (age > 0) e_ms = !mem_ready && age != TO;
    else         e_ms = mv && mem_req && !mem_ready;
    e_fl = ev && branch_taken && !e_ms;
    hit = (de_rs1_used && de_rs1 == ex_rd)
       || (de_rs2_used && de_rs2 == ex_rd);
    e_lu = ev && dv && ex_memRead2 && ex_regWrite
        && ex_rd != 0 && hit && !e_fl && !e_ms;
    e_fa = ref_fwd(ex_rs1_used, ex_rs1);
    e_fb = ref_fwd(ex_rs2_used, ex_rs2);
  endtask

  task automatic check_all();
    predict();
    chk("stall_pc", stall_pc, e_ms | e_lu);
    chk("stall_if", stall_if, e_ms | e_lu);
    chk("stall_de", stall_de, e_ms | e_lu);
    chk("stall_ex", stall_ex, e_ms);
    chk("stall_mem", stall_mem, e_ms);
    chk("if_de_inv", if_de_invalid, inv[0]);
    chk("de_ex_inv", de_ex_invalid, inv[1]);
    chk("ex_mem_inv", ex_mem_invalid, inv[2]);
    chk("mem_wb_inv", mem_wb_invalid, inv[3]);
    chk("fwd_a", fwd_a_sel, e_fa);
    chk("fwd_b", fwd_b_sel, e_fb);
    chk("timeout", mem_timeout, e_to);
    chk("stall_cnt", stall_cycles, sc);
    chk("flush_cnt", flush_count, fc);
  endtask

  task automatic advance();
    bit fs, bs;
    if (RESET) begin
      inv = '{1, 1, 1, 1};
      age = 0;
      sc = 0;
      fc = 0;
    end else begin
      fs = e_ms | e_lu;
      bs = e_ms;
      n0 = fs ? inv[0] : e_fl;
      n1 = !fs ? (inv[0] | e_fl) : (!bs ? 1'b1 : inv[1]);
      n2 = bs ? inv[2] : inv[1];
      n3 = (e_to || bs) ? 1'b1 : inv[2];
      inv = '{n0, n1, n2, n3};
      age = e_ms ? age + 1 : 0;
      sc = sc + 32'(fs);
      fc = fc + 32'(e_fl);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    advance();
    #1;
  endtask

  task automatic clr();
    {de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {de_rs1_used, de_rs2_used, ex_rs1_used, ex_rs2_used} = '0;
    {ex_regWrite, ex_memRead2, branch_taken} = '0;
    {mem_regWrite, mem_req, mem_ready, wb_regWrite} = '0;
  endtask

  initial begin
    clr();
    RESET = 1'b1;
    inv = '{1, 1, 1, 1};
    age = 0;
    sc = 0;
    fc = 0;
    @(posedge CLK);
    #1;
    chk("rst_ifde", if_de_invalid, 1);
    chk("rst_memwb", mem_wb_invalid, 1);
    chk("rst_stall", stall_pc, 0);
    chk("rst_cnt", stall_cycles, 0);
    tick();

    // Drain after reset
    RESET = 1'b0;
    repeat (4) tick();
    chk("drain_ifde", if_de_invalid, 0);
    chk("drain_deex", de_ex_invalid, 0);
    chk("drain_exmem", ex_mem_invalid, 0);
    chk("drain_memwb", mem_wb_invalid, 0);

    // Load x5 in EX, consumer in DE
    ex_memRead2 = 1; ex_regWrite = 1; ex_rd = 5;
    de_rs1 = 5; de_rs1_used = 1;
    #1;
    chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_de", stall_de, 1);
    chk("lu_stall_ex", stall_ex, 0);
    tick();
    chk("lu_bubble", de_ex_invalid, 1);
    clr();
    de_rs1 = 5; de_rs1_used = 1;
    mem_rd = 5; mem_regWrite = 1; mem_req = 1; mem_ready = 1;
    tick();
    clr();
    ex_rs1 = 5; ex_rs1_used = 1;
    wb_rd = 5; wb_regWrite = 1;
    #1;
    chk("lu_fwd_a", fwd_a_sel, 2);
    chk("lu_cnt", stall_cycles, 1);
    tick();

    // Taken branch with an illegal load-use alongside
    clr();
    branch_taken = 1; ex_memRead2 = 1; ex_regWrite = 1; ex_rd = 7;
    de_rs2 = 7; de_rs2_used = 1;
    #1;
    chk("br_no_stall", stall_de, 0);
    tick();
    chk("br_ifde", if_de_invalid, 1);
    chk("br_deex", de_ex_invalid, 1);
    chk("br_cnt", flush_count, 1);
    clr();
    repeat (4) tick();

    // Store waiting three cycles for memory
    mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stall_pc", stall_pc, 1);
      chk("mw_stall_mem", stall_mem, 1);
      tick();
      chk("mw_memwb", mem_wb_invalid, 1);
    end
    mem_ready = 1;
    #1;
    chk("mw_done", stall_pc, 0);
    chk("mw_cnt", stall_cycles, 4);
    tick();

    // Memory never answers: abandoned after TO wait cycles
    clr();
    mem_req = 1;
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("to_hold", stall_mem, 1);
      chk("to_quiet", mem_timeout, 0);
      tick();
    end
    #1;
    chk("to_pulse", mem_timeout, 1);
    chk("to_release", stall_mem, 0);
    tick();
    chk("to_dropped", mem_wb_invalid, 1);
    chk("to_once", mem_timeout, 0);
    clr();
    #1;
    chk("to_cnt", stall_cycles, 8);

    // x3 produced by both MEM and WB
    ex_rs1 = 3; ex_rs2 = 3; ex_rs1_used = 1; ex_rs2_used = 1;
    mem_rd = 3; mem_regWrite = 1; wb_rd = 3; wb_regWrite = 1;
    tick();
    chk("fw_a_mem", fwd_a_sel, 1);
    chk("fw_b_mem", fwd_b_sel, 1);
    mem_rd = 0; wb_rd = 0;
    #1;
    chk("fw_a_x0", fwd_a_sel, 0);
    chk("fw_b_x0", fwd_b_sel, 0);
    tick();

    // Reset in the middle of a wait
    clr();
    mem_req = 1;
    tick();
    tick();
    RESET = 1;
    #1;
    chk("rw_no_pulse", mem_timeout, 0);
    tick();
    chk("rw_idle", stall_mem, 0);
    chk("rw_inv", if_de_invalid, 1);
    RESET = 0;
    clr();

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      RESET        = ($urandom_range(99) == 0);
      de_rs1       = 5'($urandom_range(3));
      de_rs2       = 5'($urandom_range(3));
      ex_rs1       = 5'($urandom_range(3));
      ex_rs2       = 5'($urandom_range(3));
      ex_rd        = 5'($urandom_range(3));
      mem_rd       = 5'($urandom_range(3));
      wb_rd        = 5'($urandom_range(3));
      de_rs1_used  = 1'($urandom_range(1));
      de_rs2_used  = 1'($urandom_range(1));
      ex_rs1_used  = 1'($urandom_range(1));
      ex_rs2_used  = 1'($urandom_range(1));
      ex_regWrite  = 1'($urandom_range(1));
      ex_memRead2  = ($urandom_range(2) == 0);
      branch_taken = ($urandom_range(7) == 0);
      if (branch_taken) ex_memRead2 = 0;
      mem_regWrite = 1'($urandom_range(1));
      mem_req      = 1'($urandom_range(1));
      mem_ready    = ($urandom_range(2) == 0);
      wb_regWrite  = 1'($urandom_range(1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
